// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - 4-bit FSM state encodings
//   - opcode (IR[31:26]) and R-type funct (IR[5:0]) constants
//   - ALU operation codes and datapath mux select codes
//   - small decode helpers for the supported instruction classes
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes (native width; the top zero-extends to ALUCTL_W)
  localparam int         ALU_CODE_W = 3;
  localparam logic [2:0] ALU_SUB    = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_SLT    = 3'b100;

  // ALUSrcB mux
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSrc mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_rtype_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic is_itype_op(input logic [5:0] o);
    return (o == OP_ADDI) || (o == OP_SLTI) || (o == OP_ANDI) || (o == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// -----------------------------------------------------------------------------
// mc_alu_decode
// Combinational ALU-operation and immediate-extension decoder.
// Ports:
//   state   in  current FSM state
//   op      in  IR[31:26]
//   funct   in  IR[5:0]
//   alu_ctl out ALU operation code (ALU_* from mc_ctrl_pkg)
//   ext_sel out 0 = zero-extend immediate, 1 = sign-extend immediate
// -----------------------------------------------------------------------------
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_e                state,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  output logic [ALU_CODE_W-1:0] alu_ctl,
  output logic                  ext_sel
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves one unassigned would infer a latch.
    alu_ctl = ALU_SUB;
    ext_sel = 1'b0;

    case (state)
      S_FETCH: alu_ctl = ALU_ADD;

      // DECODE forms the branch target; MEMADR forms the load/store address.
      S_DECODE, S_MEMADR: begin
        alu_ctl = ALU_ADD;
        ext_sel = 1'b1;
      end

      // ALUWB keeps the EXEC operation so ALUOut stays stable for write-back.
      S_EXEC_R, S_EXEC_I, S_ALUWB: begin
        if (op == OP_RTYPE) begin
          case (funct)
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: alu_ctl = ALU_ADD;
          endcase
        end else begin
          case (op)
            OP_SLTI: begin alu_ctl = ALU_SLT; ext_sel = 1'b1; end
            OP_ANDI: alu_ctl = ALU_AND;
            OP_ORI:  alu_ctl = ALU_OR;
            default: begin alu_ctl = ALU_ADD; ext_sel = 1'b1; end
          endcase
        end
      end

      S_BRANCH: alu_ctl = ALU_SUB;

      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle MIPS control unit. Sequences the datapath through
// FETCH/DECODE/EXEC/MEM/WB states from the instruction register's op/funct.
// Ports:
//   clk, reset (sync, active-low)     clock and reset
//   op, funct                         IR[31:26], IR[5:0]
//   mem_ready                         memory access completes this cycle
//   IorD, MemWrite, IRWrite           memory address select / write / IR load
//   RegDest, Mem_to_Reg, RegWrite     register-file write controls
//   ALUSrcA, ALUSrcB, ALUControl      ALU operand selects and operation
//   ext_sel                           immediate extension (1 = sign)
//   PCSrc, PCWrite, branch, branch_ne PC update controls
//   illegal                           sticky trap indicator
//   state_o                           current state (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W        = 3,
  parameter bit HAS_MEM_WAIT    = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDest,
  output logic                Mem_to_Reg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                ext_sel,
  output logic [1:0]          PCSrc,
  output logic                PCWrite,
  output logic                branch,
  output logic                branch_ne,
  output logic                illegal,
  output logic [3:0]          state_o
);

  localparam state_e ILLEGAL_NEXT = state_e'(TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH);

  state_e                state_q, state_d;
  logic                  ready;
  logic                  pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic [ALU_CODE_W-1:0] alu_ctl;

  // Without a wait-capable memory every access completes in one cycle.
  assign ready = HAS_MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    IorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDest       = 1'b0;
    Mem_to_Reg    = 1'b0;
    reg_write_raw = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    PCSrc         = PCSRC_ALU;
    pc_write_raw  = 1'b0;
    branch        = 1'b0;
    branch_ne     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        if (ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_d      = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (op)
          OP_LW, OP_SW:                   state_d = S_MEMADR;
          OP_RTYPE:                       state_d = is_rtype_funct(funct) ? S_EXEC_R : ILLEGAL_NEXT;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                 state_d = S_BRANCH;
          OP_J:                           state_d = S_JUMP;
          default:                        state_d = ILLEGAL_NEXT;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        IorD = 1'b1;
        if (ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write_raw = 1'b1;
        Mem_to_Reg    = 1'b1;
        state_d       = S_FETCH;
      end

      // The write strobe is held until the memory accepts it, so exactly one
      // MemWrite-and-ready cycle occurs per store.
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        if (ready) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        state_d = S_ALUWB;
      end

      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write_raw = 1'b1;
        RegDest       = (op == OP_RTYPE);
        ALUSrcA       = 1'b1;
        ALUSrcB       = (op == OP_RTYPE) ? SRCB_REG : SRCB_IMM;
        state_d       = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_REG;
        PCSrc     = PCSRC_ALUOUT;
        branch    = (op == OP_BEQ);
        branch_ne = (op == OP_BNE);
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        PCSrc        = PCSRC_JUMP;
        pc_write_raw = 1'b1;
        state_d      = S_FETCH;
      end

      // Only reset leaves TRAP.
      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase
  end

  // Architectural writes are suppressed for the whole time reset is low, so
  // an instruction interrupted by reset commits nothing.
  assign PCWrite  = pc_write_raw  & reset;
  assign IRWrite  = ir_write_raw  & reset;
  assign MemWrite = mem_write_raw & reset;
  assign RegWrite = reg_write_raw & reset;

  mc_alu_decode u_alu_decode (
    .state   (state_q),
    .op      (op),
    .funct   (funct),
    .alu_ctl (alu_ctl),
    .ext_sel (ext_sel)
  );

  assign ALUControl = ALUCTL_W'(alu_ctl);
  assign illegal    = (state_q == S_TRAP);
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed testbench for mc_control_fsm. A second instance built with
// TRAP_ON_ILLEGAL=0 shares all inputs and is used for the NOP-on-illegal case.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] op        = 6'h00;
  logic [5:0] funct     = 6'h00;

  logic       IorD, MemWrite, IRWrite, RegDest, Mem_to_Reg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       ext_sel, PCWrite, branch, branch_ne, illegal;
  logic [3:0] state_o;

  logic       n_IorD, n_MemWrite, n_IRWrite, n_RegDest, n_Mem_to_Reg, n_RegWrite, n_ALUSrcA;
  logic [1:0] n_ALUSrcB, n_PCSrc;
  logic [2:0] n_ALUControl;
  logic       n_ext_sel, n_PCWrite, n_branch, n_branch_ne, n_illegal;
  logic [3:0] n_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control_fsm #(.ALUCTL_W(3), .HAS_MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDest(RegDest),
    .Mem_to_Reg(Mem_to_Reg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ext_sel(ext_sel), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .branch(branch), .branch_ne(branch_ne), .illegal(illegal),
    .state_o(state_o)
  );

  mc_control_fsm #(.ALUCTL_W(3), .HAS_MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .IorD(n_IorD), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .RegDest(n_RegDest),
    .Mem_to_Reg(n_Mem_to_Reg), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA),
    .ALUSrcB(n_ALUSrcB), .ALUControl(n_ALUControl), .ext_sel(n_ext_sel), .PCSrc(n_PCSrc),
    .PCWrite(n_PCWrite), .branch(n_branch), .branch_ne(n_branch_ne), .illegal(n_illegal),
    .state_o(n_state_o)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; op = 6'h23; funct = 6'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_enables edge %0d: got %b expected 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end
    n_checks++;
    if (state_o !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_FETCH);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({IRWrite, PCWrite, ALUSrcB, ALUControl, illegal} !== {1'b1, 1'b1, 2'b01, 3'b001, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_fetch_outputs: got IRWrite=%b PCWrite=%b ALUSrcB=%b ALUControl=%b illegal=%b expected 1 1 01 001 0",
               IRWrite, PCWrite, ALUSrcB, ALUControl, illegal);
    end
  endtask

  task automatic test_lw();
    state_e exp_st [8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
    op = 6'h23; funct = 6'h00;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (state_o !== 4'(exp_st[i])) begin
        n_fail++; $display("FAIL lw_state cycle %0d: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if ({RegWrite, Mem_to_Reg} !== {2{i == 6}}) begin
        n_fail++; $display("FAIL lw_writeback cycle %0d: got %b expected %b", i, {RegWrite, Mem_to_Reg}, {2{i == 6}});
      end
      n_checks++;
      if (IorD !== (i >= 3 && i <= 5)) begin
        n_fail++; $display("FAIL lw_iord cycle %0d: got %b expected %b", i, IorD, (i >= 3 && i <= 5));
      end
    end
    mem_ready = 1'b1;
  endtask

  // Store with a given number of not-ready cycles in MEMWR.
  task automatic test_sw(input int waits);
    int     commits = 0;
    state_e exp_st;
    op = 6'h2B; funct = 6'h00;
    for (int i = 0; i <= 4 + waits; i++) begin
      if (i > 0) step();
      mem_ready = (i >= 3 && i < 3 + waits) ? 1'b0 : 1'b1;
      #1;
      if (i == 0 || i == 4 + waits) exp_st = S_FETCH;
      else if (i == 1)              exp_st = S_DECODE;
      else if (i == 2)              exp_st = S_MEMADR;
      else                          exp_st = S_MEMWR;
      n_checks++;
      if (state_o !== 4'(exp_st)) begin
        n_fail++; $display("FAIL sw%0d_state cycle %0d: got %0d expected %0d", waits, i, state_o, exp_st);
      end
      n_checks++;
      if ({MemWrite, IorD} !== {2{i >= 3 && i <= 3 + waits}}) begin
        n_fail++; $display("FAIL sw%0d_memwrite cycle %0d: got %b expected %b", waits, i, {MemWrite, IorD}, {2{i >= 3 && i <= 3 + waits}});
      end
      if (MemWrite && mem_ready) commits++;
    end
    n_checks++;
    if (commits !== 1) begin
      n_fail++; $display("FAIL sw%0d_commits: got %0d expected 1", waits, commits);
    end
    mem_ready = 1'b1;
  endtask

  // Jump preceded by one not-ready FETCH cycle.
  task automatic test_jump_fetch_wait();
    state_e exp_st [5] = '{S_FETCH, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
    op = 6'h02; funct = 6'h00;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      mem_ready = (i == 0) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (state_o !== 4'(exp_st[i])) begin
        n_fail++; $display("FAIL jump_state cycle %0d: got %0d expected %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if ({PCWrite, IRWrite} !== {(i == 1 || i == 3 || i == 4), (i == 1 || i == 4)}) begin
        n_fail++; $display("FAIL jump_enables cycle %0d: got %b%b", i, PCWrite, IRWrite);
      end
      if (i == 3) begin
        n_checks++;
        if (PCSrc !== 2'b10) begin
          n_fail++; $display("FAIL jump_pcsrc: got %b expected 10", PCSrc);
        end
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] alu [5] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100};
    state_e exp_st [5] = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB, S_FETCH};
    for (int k = 0; k < 5; k++) begin
      op = 6'h00; funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        #1;
        n_checks++;
        if (state_o !== 4'(exp_st[i])) begin
          n_fail++; $display("FAIL rtype_%h_state cycle %0d: got %0d expected %0d", fn[k], i, state_o, exp_st[i]);
        end
        if (i == 1) begin
          n_checks++;
          if ({ALUSrcB, ext_sel, ALUControl} !== {2'b11, 1'b1, 3'b001}) begin
            n_fail++; $display("FAIL decode_outputs: got %b %b %b expected 11 1 001", ALUSrcB, ext_sel, ALUControl);
          end
        end
        if (i == 2) begin
          n_checks++;
          if ({ALUControl, ALUSrcA, ALUSrcB, RegWrite} !== {alu[k], 1'b1, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL rtype_%h_exec: got %b %b %b %b expected %b 1 00 0", fn[k], ALUControl, ALUSrcA, ALUSrcB, RegWrite, alu[k]);
          end
        end
        if (i == 3) begin
          n_checks++;
          if ({ALUControl, RegDest, RegWrite, Mem_to_Reg} !== {alu[k], 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL rtype_%h_wb: got %b %b %b %b expected %b 1 1 0", fn[k], ALUControl, RegDest, RegWrite, Mem_to_Reg, alu[k]);
          end
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] opc [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic [2:0] alu [4] = '{3'b001, 3'b100, 3'b010, 3'b011};
    logic       ext [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    state_e exp_st [5] = '{S_FETCH, S_DECODE, S_EXEC_I, S_ALUWB, S_FETCH};
    for (int k = 0; k < 4; k++) begin
      op = opc[k]; funct = 6'h2A;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        #1;
        n_checks++;
        if (state_o !== 4'(exp_st[i])) begin
          n_fail++; $display("FAIL itype_%h_state cycle %0d: got %0d expected %0d", opc[k], i, state_o, exp_st[i]);
        end
        if (i == 2) begin
          n_checks++;
          if ({ALUControl, ext_sel, ALUSrcA, ALUSrcB} !== {alu[k], ext[k], 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL itype_%h_exec: got %b %b %b %b expected %b %b 1 10", opc[k], ALUControl, ext_sel, ALUSrcA, ALUSrcB, alu[k], ext[k]);
          end
        end
        if (i == 3) begin
          n_checks++;
          if ({ALUControl, ext_sel, RegDest, RegWrite} !== {alu[k], ext[k], 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL itype_%h_wb: got %b %b %b %b expected %b %b 0 1", opc[k], ALUControl, ext_sel, RegDest, RegWrite, alu[k], ext[k]);
          end
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc [2] = '{6'h04, 6'h05};
    state_e exp_st [4] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
    for (int k = 0; k < 2; k++) begin
      op = opc[k]; funct = 6'h00;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        #1;
        n_checks++;
        if (state_o !== 4'(exp_st[i])) begin
          n_fail++; $display("FAIL branch_%h_state cycle %0d: got %0d expected %0d", opc[k], i, state_o, exp_st[i]);
        end
        if (i == 2) begin
          n_checks++;
          if ({branch, branch_ne, PCSrc, ALUControl, ALUSrcA, ALUSrcB, PCWrite} !==
              {(k == 0), (k == 1), 2'b01, 3'b000, 1'b1, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL branch_%h_outputs: got beq=%b bne=%b PCSrc=%b ALU=%b A=%b B=%b PCWrite=%b",
                               opc[k], branch, branch_ne, PCSrc, ALUControl, ALUSrcA, ALUSrcB, PCWrite);
          end
        end
      end
    end
  endtask

  // Illegal opcode, then an unsupported R-type funct; reset clears each trap.
  task automatic test_illegal();
    logic [5:0] opc [2] = '{6'h3F, 6'h00};
    logic [5:0] fnc [2] = '{6'h00, 6'h21};
    int         n_cyc [2] = '{12, 3};
    for (int k = 0; k < 2; k++) begin
      op = opc[k]; funct = fnc[k];
      for (int i = 0; i < n_cyc[k]; i++) begin
        if (i > 0) step();
        #1;
        n_checks++;
        if (state_o !== 4'((i == 0) ? S_FETCH : (i == 1) ? S_DECODE : S_TRAP)) begin
          n_fail++; $display("FAIL illegal%0d_state cycle %0d: got %0d", k, i, state_o);
        end
        n_checks++;
        if (illegal !== (i >= 2)) begin
          n_fail++; $display("FAIL illegal%0d_flag cycle %0d: got %b expected %b", k, i, illegal, (i >= 2));
        end
        if (i >= 2) begin
          n_checks++;
          if ({PCWrite, IRWrite, MemWrite, RegWrite, branch, branch_ne} !== 6'b0) begin
            n_fail++; $display("FAIL illegal%0d_enables cycle %0d: got %b expected 000000", k, i,
                               {PCWrite, IRWrite, MemWrite, RegWrite, branch, branch_ne});
          end
        end
        if (i == 2) begin
          n_checks++;
          if (n_state_o !== 4'(S_FETCH) || n_illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal%0d_nop_variant: got state %0d illegal %b expected %0d 0", k, n_state_o, n_illegal, S_FETCH);
          end
        end
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (state_o !== 4'(S_FETCH) || illegal !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_clear: got state %0d illegal %b expected %0d 0", k, state_o, illegal, S_FETCH);
      end
      reset = 1'b1;
    end
  endtask

  // Reset dropped while a store is waiting on memory.
  task automatic test_reset_mid();
    op = 6'h2B; funct = 6'h00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      mem_ready = (i == 3) ? 1'b0 : 1'b1;
      #1;
    end
    n_checks++;
    if (state_o !== 4'(S_MEMWR) || MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got state %0d MemWrite %b expected %0d 1", state_o, MemWrite, S_MEMWR);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL midreset_memwrite: got %b expected 0", MemWrite);
    end
    step();
    n_checks++;
    if (state_o !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL midreset_state: got %0d expected %0d", state_o, S_FETCH);
    end
    reset = 1'b1; mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw(0);
    test_sw(2);
    test_jump_fetch_wait();
    test_rtype();
    test_itype();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
